// File: rtl/mealy_seq_tx_pkg.sv
// Shared types and constants for the mealy_seq_tx serial pattern transmitter.
package mealy_seq_tx_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1101;

  // Fibonacci x^8+x^6+x^5+x^4+1, shifting right with the output at bit 0
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b0001_1101;

  function automatic logic lfsr_fb(input logic [7:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/mealy_seq_tx_if.sv
// Control/serial bundle between a burst requester and mealy_seq_tx.
interface mealy_seq_tx_if #(parameter int CNT_W = 8);
  logic             start;
  logic [CNT_W-1:0] reps;
  logic [3:0]       gap;
  logic             out;
  logic             valid;
  logic             mark;
  logic             busy;
  logic             done;

  modport master (output start, reps, gap, input out, valid, mark, busy, done);
  modport slave  (input start, reps, gap, output out, valid, mark, busy, done);
endinterface

// File: rtl/mealy_seq_tx_lfsr.sv
// 8-bit Fibonacci LFSR producing pseudo-random gap fill bits.
module mealy_seq_tx_lfsr
  import mealy_seq_tx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bit_out
);
  logic [7:0] s;

  always_ff @(posedge clk) begin
    if (reset)   s <= LFSR_SEED;
    else if (en) s <= {lfsr_fb(s), s[7:1]};
  end

  assign bit_out = s[0];
endmodule

// File: rtl/mealy_seq_tx.sv
// Serial pattern transmitter: repeats PATTERN reps times with optional gap bits.
// Define SEQ_TX_LFSR_FILL_EN to fill gaps from an LFSR instead of zeros.
module mealy_seq_tx
  import mealy_seq_tx_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = 8
)(
  input  logic           clk,
  input  logic           reset,
  mealy_seq_tx_if.slave  bus
);
  localparam int             IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PAT_W - 1);

  // state/idx/gcnt describe the bit currently on the registered outputs
  state_t           st, st_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [3:0]       gap_l, gap_ln;
  logic [3:0]       gcnt, gcnt_n;
  logic             out_q, valid_q, mark_q, busy_q, done_q;
  logic             out_n, valid_n, mark_n, busy_n, done_n;
  logic             fill_bit;

`ifdef SEQ_TX_LFSR_FILL_EN
  // advances on each edge that loads a gap bit, so the first gap bit is seed[0]
  mealy_seq_tx_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .en      (st_n == GAP),
    .bit_out (fill_bit)
  );
`else
  assign fill_bit = 1'b0;
`endif

  always_comb begin
    st_n   = st;
    idx_n  = idx;
    rem_n  = rem;
    gap_ln = gap_l;
    gcnt_n = gcnt;
    done_n = 1'b0;
    case (st)
      IDLE: begin
        if (bus.start) begin
          if (bus.reps != '0) begin
            st_n   = SEND;
            idx_n  = LAST;
            rem_n  = bus.reps;
            gap_ln = bus.gap;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SEND: begin
        if (idx == '0) begin
          rem_n = (rem != '0) ? rem - 1'b1 : rem;
          if (rem <= CNT_W'(1)) begin
            st_n   = IDLE;
            done_n = 1'b1;
          end else if (gap_l == 4'd0) begin
            idx_n = LAST;
          end else begin
            st_n   = GAP;
            gcnt_n = gap_l;
          end
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      GAP: begin
        gcnt_n = gcnt - 4'd1;
        if (gcnt <= 4'd1) begin
          st_n  = SEND;
          idx_n = LAST;
        end
      end
      default: st_n = IDLE;
    endcase

    valid_n = (st_n != IDLE);
    busy_n  = valid_n;
    mark_n  = (st_n == SEND) && (idx_n == '0);
    out_n   = 1'b0;
    if (st_n == SEND)     out_n = PATTERN[idx_n];
    else if (st_n == GAP) out_n = fill_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      idx     <= '0;
      rem     <= '0;
      gap_l   <= '0;
      gcnt    <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      mark_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st      <= st_n;
      idx     <= idx_n;
      rem     <= rem_n;
      gap_l   <= gap_ln;
      gcnt    <= gcnt_n;
      out_q   <= out_n;
      valid_q <= valid_n;
      mark_q  <= mark_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;
  assign bus.mark  = mark_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_mealy_seq_tx.sv
// Directed bench for mealy_seq_tx with a behavioural Mealy 1101 detector on out.
module tb_mealy_seq_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mealy_seq_tx_if #(.CNT_W(8)) bus ();

  mealy_seq_tx #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Mealy detector: fires in the same cycle as the final pattern bit
  logic [2:0] hist;
  logic       det;
  always_ff @(posedge clk) begin
    if (reset || !bus.valid) hist <= 3'b000;
    else                     hist <= {hist[1:0], bus.out};
  end
  assign det = bus.valid && ({hist, bus.out} == 4'b1101);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Issues one start and records the burst up to and including the done cycle.
  task automatic run_burst(input logic [7:0] r, input logic [3:0] g, output int n,
                           output logic [31:0] bits, output logic [31:0] marks,
                           output logic [31:0] dets, output logic seq_ok);
    logic got_done;
    bus.start = 1'b1; bus.reps = r; bus.gap = g;
    cyc;
    bus.start = 1'b0;
    n = 0; bits = '0; marks = '0; dets = '0; seq_ok = 1'b1; got_done = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (bus.done) begin
        got_done = 1'b1;
        if (bus.busy || bus.valid) seq_ok = 1'b0;
      end else if (bus.valid) begin
        bits  = {bits[30:0], bus.out};
        marks = {marks[30:0], bus.mark};
        dets  = {dets[30:0], det};
        n++;
        if (!bus.busy) seq_ok = 1'b0;
      end else begin
        seq_ok = 1'b0;
      end
      if (!got_done) cyc;
    end
    if (!got_done) seq_ok = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  reps;
    logic [3:0]  gap;
    int          len;
    logic [31:0] bits;
    logic [31:0] marks;
    logic [31:0] pmask;
  } vec_t;

  vec_t        vt [5];
  int          n;
  logic [31:0] bits, marks, dets;
  logic        ok, seen;

  initial begin
    vt[0] = '{8'd1, 4'd0,  4, 32'b1101,             32'b0001,             32'hF};
    vt[1] = '{8'd3, 4'd0, 12, 32'b110111011101,     32'b000100010001,     32'hFFF};
    vt[2] = '{8'd2, 4'd3, 11, 32'b1101_000_1101,    32'b0001_000_0001,    32'b1111_000_1111};
    vt[3] = '{8'd2, 4'd1,  9, 32'b1101_0_1101,      32'b0001_0_0001,      32'b1111_0_1111};
    vt[4] = '{8'd4, 4'd0, 16, 32'b1101110111011101, 32'b0001000100010001, 32'hFFFF};

    reset = 1'b1; bus.start = 1'b0; bus.reps = '0; bus.gap = '0;
    cyc; cyc;
    chk("reset_outputs", {27'd0, bus.out, bus.valid, bus.mark, bus.busy, bus.done}, 32'd0);
    reset = 1'b0;
    cyc;
    chk("idle_outputs", {27'd0, bus.out, bus.valid, bus.mark, bus.busy, bus.done}, 32'd0);

    // Each vector starts during the previous done cycle: earliest legal restart
    for (int i = 0; i < 5; i++) begin
      run_burst(vt[i].reps, vt[i].gap, n, bits, marks, dets, ok);
      chk($sformatf("v%0d_len", i), n, vt[i].len);
`ifdef SEQ_TX_LFSR_FILL_EN
      chk($sformatf("v%0d_bits", i), bits & vt[i].pmask, vt[i].bits & vt[i].pmask);
      chk($sformatf("v%0d_det", i), dets & marks, marks);
`else
      chk($sformatf("v%0d_bits", i), bits, vt[i].bits);
      chk($sformatf("v%0d_det", i), dets, marks);
`endif
      chk($sformatf("v%0d_marks", i), marks, vt[i].marks);
      chk($sformatf("v%0d_timing", i), ok, 1);
    end

    cyc;
    chk("done_one_cycle", {30'd0, bus.done, bus.valid}, 32'd0);

    // reps=0: no burst, done pulse only
    bus.start = 1'b1; bus.reps = 8'd0; bus.gap = 4'd0;
    cyc;
    bus.start = 1'b0;
    chk("reps0_done", {29'd0, bus.valid, bus.busy, bus.done}, 32'b001);
    cyc;
    chk("reps0_after", {29'd0, bus.valid, bus.busy, bus.done}, 32'b000);

    // start held high and reps/gap changed mid-burst: one 8-bit burst
    bus.start = 1'b1; bus.reps = 8'd2; bus.gap = 4'd0;
    cyc;
    bus.reps = 8'd9; bus.gap = 4'd5;
    n = 0; seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (bus.done) begin seen = 1'b1; bus.start = 1'b0; end
      else begin
        if (bus.valid) n++;
        cyc;
      end
    end
    bus.start = 1'b0;
    chk("held_done_seen", seen, 1);
    chk("held_len", n, 8);
    cyc; cyc;
    chk("held_no_rerun", {30'd0, bus.valid, bus.busy}, 32'd0);

    // reset on bit 6 of reps=4 gap=2 (bits 5,6 are gap bits)
    bus.start = 1'b1; bus.reps = 8'd4; bus.gap = 4'd2;
    cyc;
    bus.start = 1'b0;
    bits = '0;
    for (int c = 1; c < 6; c++) begin
      bits = {bits[30:0], bus.out};
      cyc;
    end
    chk("abort_prefix", bits[4:1], 4'b1101);
    chk("abort_bit6_valid", {30'd0, bus.valid, bus.busy}, 32'b11);
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    chk("abort_outputs", {27'd0, bus.out, bus.valid, bus.mark, bus.busy, bus.done}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc;
      if (bus.done || bus.valid) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    run_burst(8'd1, 4'd0, n, bits, marks, dets, ok);
    chk("replay_bits", bits, 32'b1101);
    chk("replay_marks", {n[7:0], marks[23:0]}, {8'd4, 24'b0001});
    chk("replay_timing", ok, 1);

`ifdef SEQ_TX_LFSR_FILL_EN
    // fresh seed: eight gap bits are the seed A5 read out LSB first
    cyc;
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    cyc;
    run_burst(8'd2, 4'd8, n, bits, marks, dets, ok);
    chk("lfsr_len", n, 16);
    chk("lfsr_bits", bits, {16'd0, 4'b1101, 8'b10100101, 4'b1101});
    chk("lfsr_marks", marks, 32'b0001_0000_0000_0001);
    chk("lfsr_det", dets & marks, marks);
    chk("lfsr_timing", ok, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
